// File: rtl/logic_gates_pkg.sv
// rtl/logic_gates_pkg.sv - shared constants and helpers for the logic-gates library
package logic_gates_pkg;

  localparam int OR_DEFAULT_WIDTH = 1;
  localparam int OR_DEFAULT_CNT_W = 16;

  // Adds one to value and stops at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32)
      max_val = 32'hFFFF_FFFF;
    else
      max_val = (32'd1 << width) - 32'd1;
    if (value >= max_val)
      return max_val;
    else
      return value + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-high clear
module sat_counter
  import logic_gates_pkg::*;
#(
  parameter int CNT_W = OR_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("sat_counter: CNT_W must be in 1..32");
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc)
      cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
  end

endmodule

// File: rtl/or_gate.sv
// rtl/or_gate.sv - bitwise two-input OR with registered copy and activity monitor
module or_gate
  import logic_gates_pkg::*;
#(
  parameter int WIDTH = OR_DEFAULT_WIDTH,
  parameter int CNT_W = OR_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             any_hi,
  output logic [CNT_W-1:0] hi_cnt
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("or_gate: WIDTH must be in 1..64");
  end

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("or_gate: CNT_W must be in 1..32");
  end

  // No masking: an X input only resolves when the other operand is 1.
  assign y      = a | b;
  assign any_hi = |y;

  always_ff @(posedge clk) begin
    if (rst)
      y_q <= '0;
    else
      y_q <= y;
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hi_cnt (
    .clk(clk),
    .rst(rst),
    .inc(any_hi),
    .cnt(hi_cnt)
  );

endmodule

// File: tb/tb_or_gate.sv
// tb/tb_or_gate.sv - self-checking bench for or_gate at WIDTH 1 and 8 and a 2-bit counter
module tb_or_gate;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a1 = 1'b0, b1 = 1'b0;
  logic       y1, yq1, any1;
  logic [15:0] cnt1;

  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic [7:0] y8, yq8;
  logic       any8;
  logic [15:0] cnt8;

  logic       as = 1'b0, bs = 1'b0;
  logic       ys, yqs, anys;
  logic [1:0] cnts;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  // Reference model: plain integers updated once per rising edge.
  bit model_valid = 1'b0;
  longint m_yq1, m_cnt1, m_yq8, m_cnt8, m_yqs, m_cnts;

  always #10 clk = ~clk;

  or_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .y(y1), .y_q(yq1), .any_hi(any1), .hi_cnt(cnt1)
  );

  or_gate #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8),
    .y(y8), .y_q(yq8), .any_hi(any8), .hi_cnt(cnt8)
  );

  or_gate #(.WIDTH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(as), .b(bs),
    .y(ys), .y_q(yqs), .any_hi(anys), .hi_cnt(cnts)
  );

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint bump(input longint cur, input longint limit);
    return (cur + 1 > limit) ? limit : cur + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_yq1 = 0; m_cnt1 = 0;
      m_yq8 = 0; m_cnt8 = 0;
      m_yqs = 0; m_cnts = 0;
      model_valid = 1'b1;
    end else begin
      m_yq1 = longint'(a1) + longint'(b1) - longint'(a1 & b1);
      if (m_yq1 != 0) m_cnt1 = bump(m_cnt1, 65535);
      m_yq8 = 0;
      for (int i = 0; i < 8; i++)
        if (a8[i] == 1'b1 || b8[i] == 1'b1) m_yq8 += (64'd1 << i);
      if (m_yq8 != 0) m_cnt8 = bump(m_cnt8, 65535);
      m_yqs = (as == 1'b1 || bs == 1'b1) ? 1 : 0;
      if (m_yqs != 0) m_cnts = bump(m_cnts, 3);
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      longint exp8;
      exp8 = 0;
      for (int i = 0; i < 8; i++)
        if (a8[i] == 1'b1 || b8[i] == 1'b1) exp8 += (64'd1 << i);
      check("cyc_y1", longint'(y1), (a1 == 1'b1 || b1 == 1'b1) ? 1 : 0);
      check("cyc_any1", longint'(any1), (a1 == 1'b1 || b1 == 1'b1) ? 1 : 0);
      check("cyc_y8", longint'(y8), exp8);
      check("cyc_any8", longint'(any8), (exp8 != 0) ? 1 : 0);
      check("cyc_ys", longint'(ys), (as == 1'b1 || bs == 1'b1) ? 1 : 0);
      if (model_valid) begin
        check("cyc_yq1", longint'(yq1), m_yq1);
        check("cyc_cnt1", longint'(cnt1), m_cnt1);
        check("cyc_yq8", longint'(yq8), m_yq8);
        check("cyc_cnt8", longint'(cnt8), m_cnt8);
        check("cyc_yqs", longint'(yqs), m_yqs);
        check("cyc_cnts", longint'(cnts), m_cnts);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] tt_a;
    logic [1:0] tt_b;
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic [1:0] sat_exp [5];
    tt_a = 2'b0;
    tt_b = 2'b0;
    va = '{8'hA0, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C};
    vb = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC3};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    step();
    // Truth table during reset, 10 ns settle per vector.
    for (int i = 0; i < 4; i++) begin
      tt_a = 2'(i >> 1);
      tt_b = 2'(i & 1);
      a1 = tt_a[0];
      b1 = tt_b[0];
      #10;
      check("tt_y", longint'(y1), (i == 0) ? 0 : 1);
      check("tt_any", longint'(any1), (i == 0) ? 0 : 1);
    end
    a1 = 1'b0;
    b1 = 1'b1;
    #1;
    check("rst_y_immediate", longint'(y1), 1);
    step();
    check("rst_yq_held", longint'(yq1), 0);
    check("rst_cnt_held", longint'(cnt1), 0);

    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    as = 1'b1;
    check("yq_before_edge", longint'(yq1), 0);
    step();
    check("yq_after_edge", longint'(yq1), 1);
    check("sat_cnt_0", longint'(cnts), longint'(sat_exp[0]));
    a1 = 1'b0;
    step();
    check("yq_back_to_0", longint'(yq1), 0);
    check("sat_cnt_1", longint'(cnts), longint'(sat_exp[1]));
    for (int i = 2; i < 5; i++) begin
      step();
      check("sat_cnt_n", longint'(cnts), longint'(sat_exp[i]));
    end

    a8 = 8'hA0; b8 = 8'h05;
    #5;
    check("v8_y_a5", longint'(y8), 64'hA5);
    check("v8_any_1", longint'(any8), 1);
    a8 = 8'h00; b8 = 8'h00;
    #2;
    check("v8_y_00", longint'(y8), 0);
    check("v8_any_0", longint'(any8), 0);

    // dut1 has counted one active edge; four more reach 5.
    a1 = 1'b1;
    repeat (4) step();
    check("cnt1_pre_reset", longint'(cnt1), 5);
    rst = 1'b1;
    step();
    check("rst_prio_cnt", longint'(cnt1), 0);
    check("rst_prio_yq", longint'(yq1), 0);
    rst = 1'b0;
    step();
    check("cnt_resume", longint'(cnt1), 1);
    check("yq_resume", longint'(yq1), 1);

    for (int i = 0; i < 6; i++) begin
      a8 = va[i];
      b8 = vb[i];
      a1 = a8[0];
      b1 = b8[7];
      step();
    end
    check("yq8_last", longint'(yq8), 64'hFF);
    check("cnt8_sweep", longint'(cnt8), 5);

    @(posedge clk);
    done = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
